// File: rtl/dfd_tr_axi_wr_sink_pkg.sv
// Shared types for the trace AXI write sink: AXI channel structs, widths and FSM states.
package dfd_tr_axi_wr_sink_pkg;

    localparam int unsigned AxiDataW = 512;
    localparam int unsigned AxiAddrW = 52;
    localparam int unsigned AxiStrbW = AxiDataW / 8;
    localparam int unsigned AxiIdW   = 8;
    localparam int unsigned AxiUserW = 1;

    localparam logic [1:0] AxiBurstFixed = 2'b00;
    localparam logic [1:0] AxiBurstIncr  = 2'b01;
    localparam logic [1:0] AxiRespOkay   = 2'b00;
    localparam logic [1:0] AxiRespSlverr = 2'b10;
    localparam logic [1:0] AxiRespDecerr = 2'b11;

    // Only full 64-byte beats map onto a memory line.
    localparam logic [2:0] SinkBeatSize = 3'd6;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } dfd_tr_ax_chan_t;

    typedef struct packed {
        logic [AxiDataW-1:0] data;
        logic [AxiStrbW-1:0] strb;
        logic                last;
    } dfd_tr_w_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [1:0]          resp;
        logic [AxiUserW-1:0] user;
    } dfd_tr_b_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiDataW-1:0] data;
        logic [1:0]          resp;
        logic                last;
        logic [AxiUserW-1:0] user;
    } dfd_tr_r_chan_t;

    typedef struct packed {
        dfd_tr_ax_chan_t aw;
        logic            aw_valid;
        dfd_tr_w_chan_t  w;
        logic            w_valid;
        logic            b_ready;
        dfd_tr_ax_chan_t ar;
        logic            ar_valid;
        logic            r_ready;
    } dfd_tr_slv_axi_req_t;

    typedef struct packed {
        logic           aw_ready;
        logic           w_ready;
        dfd_tr_b_chan_t b;
        logic           b_valid;
        logic           ar_ready;
        dfd_tr_r_chan_t r;
        logic           r_valid;
    } dfd_tr_slv_axi_rsp_t;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StResp,
        StRdata
    } sink_state_e;

endpackage

// File: rtl/dfd_tr_axi_wr_sink.sv
// AXI write sink for trace data: accepts one INCR burst at a time and passes each W beat
// straight through to a line-wide memory port. Malformed or out-of-window bursts are drained
// and answered with SLVERR. Define DFD_TR_SINK_RD_ERR_EN to answer reads with DECERR beats;
// otherwise the read channel is tied off.
module dfd_tr_axi_wr_sink
    import dfd_tr_axi_wr_sink_pkg::*;
#(
    parameter logic [AxiAddrW-1:0] BaseAddr = '0,
    parameter int unsigned         MemDepth = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  dfd_tr_slv_axi_req_t         axi_req_i,
    output dfd_tr_slv_axi_rsp_t         axi_rsp_o,
    output logic                        mem_we_o,
    output logic [$clog2(MemDepth)-1:0] mem_addr_o,
    output logic [AxiDataW-1:0]         mem_wdata_o,
    output logic [AxiStrbW-1:0]         mem_wstrb_o,
    input  logic                        mem_ready_i,
    output logic [15:0]                 err_cnt_o
);

    localparam int unsigned         MemAddrW = $clog2(MemDepth);
    localparam logic [AxiAddrW-1:0] MemBytes = AxiAddrW'(MemDepth) << 6;

    sink_state_e         state_q, state_d;
    logic [AxiIdW-1:0]   id_q, id_d;
    logic [MemAddrW-1:0] line_q, line_d;
    logic [7:0]          len_q, len_d;
    logic [8:0]          beat_q, beat_d;
    logic                drop_q, drop_d;
    logic                slverr_q, slverr_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic [AxiAddrW-1:0] aw_off;
    logic                aw_bad;
    logic                final_beat;
    logic                unused_req;

    // An address below BaseAddr wraps to a huge offset and so lands out of window.
    assign aw_off     = axi_req_i.aw.addr - BaseAddr;
    assign aw_bad     = (axi_req_i.aw.burst != AxiBurstIncr) ||
                        (axi_req_i.aw.size != SinkBeatSize) ||
                        (aw_off >= MemBytes);
    assign final_beat = (beat_q == {1'b0, len_q});

    assign mem_addr_o  = line_q + MemAddrW'(beat_q);
    assign mem_wdata_o = axi_req_i.w.data;
    assign mem_wstrb_o = axi_req_i.w.strb;
    assign err_cnt_o   = reset ? '0 : err_cnt_q;

    assign unused_req = ^{axi_req_i.ar, axi_req_i.ar_valid, axi_req_i.r_ready};

    // State and burst context registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            id_q      <= '0;
            line_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            drop_q    <= 1'b0;
            slverr_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            line_q    <= line_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            drop_q    <= drop_d;
            slverr_q  <= slverr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next state, AXI handshakes and the zero-latency memory write.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        line_d    = line_q;
        len_d     = len_q;
        beat_d    = beat_q;
        drop_d    = drop_q;
        slverr_d  = slverr_q;
        err_cnt_d = err_cnt_q;
        mem_we_o  = 1'b0;

        axi_rsp_o        = '0;
        axi_rsp_o.b.id   = id_q;
        axi_rsp_o.b.resp = slverr_q ? AxiRespSlverr : AxiRespOkay;
        axi_rsp_o.r.id   = id_q;
        axi_rsp_o.r.resp = AxiRespDecerr;

        unique case (state_q)
            StIdle: begin
                axi_rsp_o.aw_ready = 1'b1;
                if (axi_req_i.aw_valid) begin
                    id_d     = axi_req_i.aw.id;
                    line_d   = aw_off[MemAddrW+5:6];
                    len_d    = axi_req_i.aw.len;
                    beat_d   = '0;
                    drop_d   = aw_bad;
                    slverr_d = aw_bad;
                    state_d  = StData;
`ifdef DFD_TR_SINK_RD_ERR_EN
                end else begin
                    axi_rsp_o.ar_ready = 1'b1;
                    if (axi_req_i.ar_valid) begin
                        id_d    = axi_req_i.ar.id;
                        len_d   = axi_req_i.ar.len;
                        beat_d  = '0;
                        state_d = StRdata;
                    end
`endif
                end
            end
            StData: begin
                // A dropped burst drains at full rate regardless of the memory.
                axi_rsp_o.w_ready = mem_ready_i | drop_q;
                if (axi_req_i.w_valid && axi_rsp_o.w_ready) begin
                    mem_we_o = ~drop_q;
                    beat_d   = beat_q + 9'd1;
                    if (axi_req_i.w.last || final_beat) begin
                        state_d  = StResp;
                        // last before the final beat means a truncated burst
                        slverr_d = drop_q | ~final_beat;
                        if (slverr_d && (err_cnt_q != 16'hFFFF)) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                end
            end
            StResp: begin
                axi_rsp_o.b_valid = 1'b1;
                if (axi_req_i.b_ready) begin
                    state_d = StIdle;
                end
            end
            StRdata: begin
`ifdef DFD_TR_SINK_RD_ERR_EN
                axi_rsp_o.r_valid = 1'b1;
                axi_rsp_o.r.last  = final_beat;
                if (axi_req_i.r_ready) begin
                    if (final_beat) begin
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase

        // The state register only clears at the next edge, so mask outputs during reset.
        if (reset) begin
            axi_rsp_o.aw_ready = 1'b0;
            axi_rsp_o.w_ready  = 1'b0;
            axi_rsp_o.b_valid  = 1'b0;
            axi_rsp_o.ar_ready = 1'b0;
            axi_rsp_o.r_valid  = 1'b0;
            mem_we_o           = 1'b0;
        end
    end

endmodule

// File: doc/dfd_tr_axi_wr_sink.md
DFD_TR_AXI_WR_SINK -- requirements
Module: dfd_tr_axi_wr_sink

Interface
REQ-001 SHALL have parameter BaseAddr, default 0, meaning the byte address that maps to mem_addr_o 0.
REQ-002 SHALL have parameter MemDepth, default 1024, meaning the number of 512-bit lines in the sink memory.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port reset  input  1  the reset; synchronous, active-high.
REQ-005 SHALL have port axi_req_i  input  dfd_tr_slv_axi_req_t  the AXI request from the trace initiator.
REQ-006 SHALL have port axi_rsp_o  output  dfd_tr_slv_axi_rsp_t  the AXI response to the trace initiator.
REQ-007 SHALL have port mem_we_o  output  1  the line write strobe.
REQ-008 SHALL have port mem_addr_o  output  $clog2(MemDepth)  the line index.
REQ-009 SHALL have port mem_wdata_o  output  512  the write data.
REQ-010 SHALL have port mem_wstrb_o  output  64  the byte enables.
REQ-011 SHALL have port mem_ready_i  input  1  memory accepts the write this cycle.
REQ-012 SHALL have port err_cnt_o  output  16  the saturating count of SLVERR bursts.

Function
REQ-013 SHALL implement the FSM states IDLE, DATA and RESP.
REQ-014 IDLE SHALL assert aw_ready; on an AW handshake the block SHALL latch id, addr, len, size and burst, and go to DATA.
REQ-015 In DATA, w_ready SHALL equal mem_ready_i OR drop, where drop = the latched burst is in error.
REQ-016 On each W handshake with drop=0, mem_we_o SHALL be 1 in the same cycle (combinational pass-through, zero latency), with mem_wdata_o = w.data and mem_wstrb_o = w.strb.
REQ-017 mem_addr_o SHALL equal ((addr - BaseAddr) >> 6) + beat index, truncated to $clog2(MemDepth) bits, so that it wraps modulo MemDepth.
REQ-018 A burst SHALL be in error when burst != INCR, size != 6, or (addr - BaseAddr) is outside MemDepth*64; an error burst SHALL consume all W beats with mem_we_o held 0.
REQ-019 On the W handshake with w.last, or on the beat count reaching len+1, the block SHALL go to RESP; a w.last that arrives early SHALL end the burst with SLVERR.
REQ-020 RESP SHALL assert b_valid with b.id = the latched id and b.resp = OKAY or SLVERR; b.user SHALL be 0.
REQ-021 b_valid SHALL hold until b_ready; on the handshake the block SHALL return to IDLE.
REQ-022 aw_ready SHALL be 0 outside IDLE, so only one outstanding write exists.
REQ-023 Each SLVERR burst SHALL increment err_cnt_o by 1, saturating at 0xFFFF.
REQ-024 An AW and W arriving in the same cycle SHALL accept only AW; W is accepted from the next cycle.

Reset
REQ-025 While reset=1 the block SHALL be in IDLE with all of the following at 0: b_valid, w_ready, mem_we_o, err_cnt_o, ar_ready, r_valid, and the beat count.
REQ-026 A reset asserted mid-burst SHALL abandon the burst with no B response.
REQ-027 aw_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-028 With DFD_TR_SINK_RD_ERR_EN defined, IDLE SHALL also accept AR when no AW is valid (AW has priority), then return len+1 R beats with data 0, resp DECERR, the AR id, and r.last on the final beat, each beat held until r_ready.
REQ-029 With DFD_TR_SINK_RD_ERR_EN undefined, ar_ready and r_valid SHALL be tied to 0.

Structure
REQ-030 The shared package SHALL hold dfd_tr_slv_axi_req_t, dfd_tr_slv_axi_rsp_t, the 512/52-bit width constants, and the sink state enum.
REQ-031 The design SHALL be a single module with no sub-modules.

Verification
REQ-032 AW addr=BaseAddr+0x80, len=3, size=6, INCR, id=5, with mem_ready_i=1 -> mem_addr_o = 2,3,4,5 on consecutive beats, then B id=5 OKAY.
REQ-033 The same burst with mem_ready_i toggling 1,0 -> w_ready follows mem_ready_i, exactly 4 mem writes occur, and B is OKAY.
REQ-034 AW with burst=FIXED, len=1 -> 2 W beats are accepted, mem_we_o stays 0, B is SLVERR, and err_cnt_o=1.
REQ-035 W with last on beat 1 of a len=3 burst -> B is SLVERR and the FSM returns to IDLE.
REQ-036 b_ready held 0 for 10 cycles -> b_valid stays 1 and aw_ready stays 0; after reset the FSM is in IDLE and aw_ready=1.
REQ-037 With DFD_TR_SINK_RD_ERR_EN defined, AR len=2 id=7 -> 3 DECERR beats with id 7 and last only on the third beat.
